// File: rtl/seg_scan_n.sv
// rtl/seg_scan_n.sv - multiplexed N-digit 7-segment scan driver with blanking, frame-latched data and polarity select
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading-zero glyphs above the highest non-zero digit)
module seg_scan_n #(
  parameter int DIGITS       = 6,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int SEG_ACT_LOW  = 0,
  parameter int DIG_ACT_LOW  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_en,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     DIG,
  output logic                  o_frame
);

  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX     = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW       = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BLK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0]     SHOW_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     BLNK_LAST = CW'(BLK_LAST);
  localparam logic [7:0]        SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF   = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {ST_SHOW = 1'b0, ST_BLANK = 1'b1} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [5*DIGITS-1:0]   pending, display;
  logic                  show_done, blank_done, advance, wrap;
  logic [7:0]            seg_n;
  logic [DIGITS-1:0]     dig_n;
  logic [3:0]            nib;
  logic                  dp_bit;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  // pending/display hold {dp, data}; display only changes at the frame wrap so a scan never tears
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_SHOW;
      cnt     <= '0;
      idx     <= '0;
      pending <= '0;
      display <= '0;
      SEG     <= SEG_OFF;
      DIG     <= DIG_OFF;
      o_frame <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      if (i_load) pending <= {i_dp, i_data};
      if (wrap)   display <= pending;
      SEG     <= seg_n ^ SEG_OFF;
      DIG     <= dig_n ^ DIG_OFF;
      o_frame <= wrap;
    end
  end

  always_comb begin
    show_done  = (state == ST_SHOW)  && (cnt == SHOW_LAST);
    blank_done = (state == ST_BLANK) && (cnt == BLNK_LAST);
    advance    = blank_done || (show_done && (BLANK_CYCLES == 0));
    wrap       = advance && (idx == IDX_LAST);
    state_n    = state;
    if (show_done && (BLANK_CYCLES > 0)) state_n = ST_BLANK;
    else if (blank_done)                 state_n = ST_SHOW;
    cnt_n = (show_done || blank_done) ? '0 : cnt + CW'(1);
    idx_n = idx;
    if (advance) idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);
  end

  `ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              above_zero;
  `endif

  always_comb begin
    nib    = display[int'(idx)*4 +: 4];
    dp_bit = display[4*DIGITS + int'(idx)];
    seg_n  = {dp_bit, font(nib)};
    `ifdef SEG_LEADING_ZERO_BLANK_EN
    // scanning from the top, a digit stays suppressed while every nibble at or above it is zero
    lz         = '0;
    above_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      above_zero = above_zero && (display[4*k +: 4] == 4'h0);
      lz[k]      = above_zero && !display[4*DIGITS + k];
    end
    if (lz[idx]) seg_n = 8'h00;
    `endif
    dig_n = DIGITS'(1) << idx;
    if (state != ST_SHOW || !i_en) begin
      dig_n = '0;
      seg_n = 8'h00;
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
// tb/tb_seg_scan_n.sv - scoreboard bench for seg_scan_n (4 digits, CLK_DIV=4, BLANK_CYCLES=1)
module tb_seg_scan_n;

  logic        clk = 1'b0;
  logic        rst, load, en;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [7:0]  seg, seg_i, seg_b;
  logic [3:0]  dig, dig_i, dig_b;
  logic        frame, frame_i, frame_b;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] sb[$];

  `ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] Z_HI = 8'h00;
  `else
  localparam logic [7:0] Z_HI = 8'h3F;
  `endif

  always #5 clk = ~clk;

  seg_scan_n #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load), .i_en(en),
    .SEG(seg), .DIG(dig), .o_frame(frame));

  seg_scan_n #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) u_inv (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load), .i_en(en),
    .SEG(seg_i), .DIG(dig_i), .o_frame(frame_i));

  seg_scan_n #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(0), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) u_nb (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load), .i_en(en),
    .SEG(seg_b), .DIG(dig_b), .o_frame(frame_b));

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 200);
    if (frame !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: o_frame=%b after %0d cycles, required 1", frame, n);
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    sb.push_back({4'b0001, s0});
    sb.push_back({4'b0010, s1});
    sb.push_back({4'b0100, s2});
    sb.push_back({4'b1000, s3});
  endtask

  task automatic capture_digit(input string name);
    int n;
    logic [11:0] exp;
    n = 0;
    while (dig === 4'b0000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty at dig=%b seg=%h", name, dig, seg);
      return;
    end
    exp = sb.pop_front();
    if ({dig, seg} !== exp) begin
      miscompares++;
      $display("FAIL %s: dig=%b seg=%h, required dig=%b seg=%h", name, dig, seg, exp[11:8], exp[7:0]);
    end
    n = 0;
    while (dig === exp[11:8] && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL %s_lit_len: %0d cycles, required 4", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; en = 1'b1; data = 16'h0; dp = 4'h0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (seg !== 8'h00 || dig !== 4'b0000 || frame !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out: seg=%h dig=%b frame=%b, required 00 0000 0", seg, dig, frame);
      end
      vectors++;
      if (seg_i !== 8'hFF || dig_i !== 4'b1111) begin
        miscompares++;
        $display("FAIL reset_inv: seg=%h dig=%b, required ff 1111", seg_i, dig_i);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (dig !== 4'b0001 || seg !== 8'h3F) begin
        miscompares++;
        $display("FAIL reset_d0_cyc%0d: dig=%b seg=%h, required 0001 3f", i, dig, seg);
      end
    end
    @(negedge clk);
    vectors++;
    if (dig !== 4'b0000 || seg !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_gap: dig=%b seg=%h, required 0000 00", dig, seg);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 4'b0010 || seg !== Z_HI) begin
      miscompares++;
      $display("FAIL reset_d1: dig=%b seg=%h, required 0010 %h", dig, seg, Z_HI);
    end
  endtask

  task automatic test_load();
    int n;
    wait_frame(n);
    load = 1'b1; data = 16'h12AF; dp = 4'b0100;
    @(negedge clk);
    load = 1'b0;
    push_frame(8'h71, 8'h77, 8'hDB, 8'h06);
    wait_frame(n);
    vectors++;
    if (n + 1 !== 20) begin
      miscompares++;
      $display("FAIL frame_period: %0d cycles, required 20", n + 1);
    end
    for (int i = 0; i < 4; i++) capture_digit("load_12af");
  endtask

  task automatic test_midframe_and_wrap_load();
    int n;
    wait_frame(n);
    repeat (2) @(negedge clk);
    load = 1'b1; data = 16'h5555; dp = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    sb.push_back({4'b0010, 8'h77});
    sb.push_back({4'b0100, 8'hDB});
    sb.push_back({4'b1000, 8'h06});
    push_frame(8'h6D, 8'h6D, 8'h6D, 8'h6D);
    n = 0;
    while (dig === 4'b0001 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 7; i++) capture_digit("midframe");
    // last capture ends on the o_frame cycle; the next wrap edge is 20 cycles on
    repeat (19) @(negedge clk);
    load = 1'b1; data = 16'h9876; dp = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (frame !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_align: o_frame=%b, required 1", frame);
    end
    push_frame(8'h6D, 8'h6D, 8'h6D, 8'h6D);
    push_frame(8'h7D, 8'h07, 8'h7F, 8'h6F);
    for (int i = 0; i < 8; i++) capture_digit("wrap_load");
  endtask

  task automatic test_enable();
    int n;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (dig !== 4'b0000 || seg !== 8'h00) begin
        miscompares++;
        $display("FAIL en_off_cyc%0d: dig=%b seg=%h, required 0000 00", i, dig, seg);
      end
    end
    en = 1'b1;
    wait_frame(n);
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL en_phase: next o_frame after %0d cycles, required 10", n);
    end
    push_frame(8'h7D, 8'h07, 8'h7F, 8'h6F);
    for (int i = 0; i < 4; i++) capture_digit("en_resume");
  endtask

  task automatic test_polarity();
    int n;
    load = 1'b1; data = 16'h0008; dp = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    wait_frame(n);
    @(negedge clk);
    vectors++;
    if (seg_i !== 8'h80 || dig_i !== 4'b1110) begin
      miscompares++;
      $display("FAIL pol_show: seg=%h dig=%b, required 80 1110", seg_i, dig_i);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (seg_i !== 8'hFF || dig_i !== 4'b1111) begin
      miscompares++;
      $display("FAIL pol_blank: seg=%h dig=%b, required ff 1111", seg_i, dig_i);
    end
  endtask

  task automatic test_leading_zero();
    int n;
    load = 1'b1; data = 16'h0030; dp = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    push_frame(8'h3F, 8'h4F, Z_HI, Z_HI);
    wait_frame(n);
    for (int i = 0; i < 4; i++) capture_digit("lz_0030");
    load = 1'b1; data = 16'h0000;
    @(negedge clk);
    load = 1'b0;
    push_frame(8'h3F, Z_HI, Z_HI, Z_HI);
    wait_frame(n);
    for (int i = 0; i < 4; i++) capture_digit("lz_0000");
  endtask

  task automatic test_no_blank();
    int n;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vectors++;
      if (!$onehot(dig_b)) begin
        miscompares++;
        $display("FAIL noblank_onehot: dig=%b, required one-hot", dig_b);
      end
    end
    n = 0;
    while (frame_b !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_b !== 1'b1 && n < 100);
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL noblank_period: %0d cycles, required 16", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    load = 1'b1; data = 16'hFFFF; dp = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    vectors++;
    if (dig !== 4'b0000 || seg !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_out: dig=%b seg=%h, required 0000 00", dig, seg);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 4'b0001 || seg !== 8'h3F) begin
      miscompares++;
      $display("FAIL rstmid_d0: dig=%b seg=%h, required 0001 3f", dig, seg);
    end
    push_frame(8'h3F, Z_HI, Z_HI, Z_HI);
    wait_frame(n);
    for (int i = 0; i < 4; i++) capture_digit("rstmid_lost");
  endtask

  initial begin
    test_reset();
    test_load();
    test_midframe_and_wrap_load();
    test_enable();
    test_polarity();
    test_leading_zero();
    test_no_blank();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
